// File: rtl/shift_seq8.sv
// shift_seq8 -- multi-cycle sequencer around an 8-bit barrel shifter.
//
// Purpose:
//   Takes one shift job (LSL/LSR/ASR/ROR, amount 0..7) per start handshake.
//   The job is carried out as a series of passes through a shifter whose
//   shift amount is limited to 0..3, so large amounts take several cycles.
//   The finished value is offered under a done handshake.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-high reset
//   start_valid  job request
//   start_ready  high only while idle; a job is accepted on start_valid & start_ready
//   op           00 LSL, 01 LSR, 10 ASR, 11 ROR (sampled at accept)
//   d_in         8-bit operand (sampled at accept)
//   amount       total shift amount 0..7 (sampled at accept)
//   result       current accumulator value; stable while done_valid is high
//   done_valid   result available
//   done_ready   consumer takes the result on done_valid & done_ready
//   busy         high while a job is shifting or waiting to be taken
//   pass_cnt     shifter passes completed for the current job

module shift_seq8 #(
  parameter int STEP_MAX = 3,
  parameter int AMT_W    = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [1:0]       op,
  input  logic [7:0]       d_in,
  input  logic [AMT_W-1:0] amount,
  output logic [7:0]       result,
  output logic             done_valid,
  input  logic             done_ready,
  output logic             busy,
  output logic [1:0]       pass_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [AMT_W-1:0] STEP_LIM = AMT_W'(STEP_MAX);

  state_t           state;
  logic [7:0]       acc;
  logic [AMT_W-1:0] rem;
  logic [1:0]       op_q;
  logic [1:0]       pass_q;

  logic [AMT_W-1:0] step;
  logic [AMT_W-1:0] rem_next;
  logic [7:0]       acc_next;

  // One pass of the barrel shifter: 8 bits in, 8 bits out, shift 0..3.
  // ASR and ROR shift a 16-bit concatenation so the bits that fall off
  // the bottom come from the sign copies or the operand itself.
  function automatic logic [7:0] shift_once(input logic [7:0] v,
                                            input logic [1:0] sel,
                                            input logic [1:0] sh);
    logic [15:0] wide;
    logic [7:0]  r;
    wide = '0;
    r    = v;
    case (sel)
      2'b00:   r = v << sh;
      2'b01:   r = v >> sh;
      2'b10: begin
        wide = {{8{v[7]}}, v} >> sh;
        r    = wide[7:0];
      end
      default: begin
        wide = {v, v} >> sh;
        r    = wide[7:0];
      end
    endcase
    return r;
  endfunction

  // Each pass takes as much of the remaining amount as the shifter allows.
  // Because every op composes additively, chained passes give the same
  // answer as a single shift by the full amount.
  always_comb begin
    step     = (rem > STEP_LIM) ? STEP_LIM : rem;
    rem_next = rem - step;
    acc_next = shift_once(acc, op_q, step[1:0]);
  end

  // Sequencer. Reset wins over everything, so a job in flight is dropped
  // without ever raising done_valid. acc is deliberately left alone on
  // DONE->IDLE so result keeps showing the last answer.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      acc    <= 8'h00;
      rem    <= '0;
      op_q   <= 2'b00;
      pass_q <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start_valid) begin
            op_q   <= op;
            acc    <= d_in;
            rem    <= amount;
            pass_q <= 2'd0;
            state  <= (amount == '0) ? DONE : SHIFT;
          end
        end
        SHIFT: begin
          acc    <= acc_next;
          rem    <= rem_next;
          pass_q <= pass_q + 2'd1;
          if (rem_next == '0) begin
            state <= DONE;
          end
        end
        DONE: begin
          if (done_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Handshake and status flags are pure decodes of the state register,
  // so they change only on clock edges.
  assign start_ready = (state == IDLE);
  assign done_valid  = (state == DONE);
  assign busy        = (state != IDLE);
  assign result      = acc;
  assign pass_cnt    = pass_q;

endmodule
